calc1_port_responder: RTL and testbench

//   Single-port responder for the calc1 request/response protocol; the target side of what the calc1 benches drive.

---
 rtl/calc1_pkg.sv | 29 ++
 rtl/calc1_alu.sv | 49 ++++
 rtl/calc1_port_responder.sv | 80 ++++++++
 tb/tb_calc1_port_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared calc1 command/response codes, FSM encodings and bus types.
// Buses are MSB-first: calc1 bit 0 (MSB) is bit 31 of the vectors here.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP2  = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef logic [3:0]  cmd_t;
    typedef logic [1:0]  resp_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        resp_t resp;
        word_t data;
    } calc1_result_t;

endpackage

// File: rtl/calc1_alu.sv
// calc1 arithmetic: add/sub/shift with overflow, underflow and invalid-command errors.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module calc1_alu
    import calc1_pkg::*;
(
    input  cmd_t          cmd,
    input  word_t         op1,
    input  word_t         op2,
    output calc1_result_t result
);

    logic [32:0] sum;
    logic [4:0]  shamt;

    always_comb begin
        sum         = {1'b0, op1} + {1'b0, op2};
        shamt       = op2[4:0];
        result.resp = RESP_ERR;
        result.data = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[32]) begin
                    result.resp = RESP_OK;
                    result.data = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    result.resp = RESP_OK;
                    result.data = op1 - op2;
                end
            end
            CMD_SHL: begin
                result.resp = RESP_OK;
                result.data = op1 << shamt;
            end
            CMD_SHR: begin
                result.resp = RESP_OK;
                result.data = op1 >> shamt;
            end
            default: begin
                // invalid commands (and NOP) keep the error response
                result.resp = RESP_ERR;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: cmd+operand1, then operand2, then one response beat.
// Latency: LATENCY edges from the operand2 capture edge to the registered response.
// Backpressure: none; commands seen while busy are dropped silently.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state;
    cmd_t          cmd_q;
    word_t         op1_q;
    word_t         op2_q;
    logic [3:0]    cnt;
    calc1_result_t alu_res;

    calc1_alu u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .result (alu_res)
    );

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            cnt      <= '0;
            out_resp <= RESP_NONE;
            out_data <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_q <= req_cmd_in;
                        op1_q <= req_data_in;
                        busy  <= 1'b1;
                        state <= ST_OP2;
                    end
                end
                ST_OP2: begin
                    op2_q <= req_data_in;
                    cnt   <= CNT_INIT;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // the response register is loaded on the LATENCY-th edge after operand2
                    if (cnt == 4'd0) begin
                        out_resp <= alu_res.resp;
                        out_data <= alu_res.data;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    out_resp <= RESP_NONE;
                    out_data <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Randomized scoreboard bench for calc1_port_responder at LATENCY 3, 1 and 15.
module tb_calc1_port_responder;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst  [NI];
    logic [3:0]  cmd  [NI];
    logic [31:0] dat  [NI];
    logic [1:0]  resp [NI];
    logic [31:0] odat [NI];
    logic        bsy  [NI];

    exp_t q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc1_port_responder #(.LATENCY(3)) u_dut_l3 (
        .c_clk(clk), .reset(rst[0]), .req_cmd_in(cmd[0]), .req_data_in(dat[0]),
        .out_resp(resp[0]), .out_data(odat[0]), .busy(bsy[0]));
    calc1_port_responder #(.LATENCY(1)) u_dut_l1 (
        .c_clk(clk), .reset(rst[1]), .req_cmd_in(cmd[1]), .req_data_in(dat[1]),
        .out_resp(resp[1]), .out_data(odat[1]), .busy(bsy[1]));
    calc1_port_responder #(.LATENCY(15)) u_dut_l15 (
        .c_clk(clk), .reset(rst[2]), .req_cmd_in(cmd[2]), .req_data_in(dat[2]),
        .out_resp(resp[2]), .out_data(odat[2]), .busy(bsy[2]));

    function automatic int lat_of(input int i);
        case (i)
            0:       return 3;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // Reference: unsigned 32-bit arithmetic straight from the calc1 rules.
    function automatic exp_t model(input int i, input logic [3:0] c,
                                   input logic [31:0] a, input logic [31:0] b, input int due);
        exp_t        e;
        longint      s;
        int unsigned amt;
        e.inst = i;
        e.cyc  = due;
        e.resp = 2'd2;
        e.data = 32'd0;
        amt    = b % 32;
        case (c)
            4'd1: begin
                s = longint'({32'd0, a}) + longint'({32'd0, b});
                if (s <= 64'hFFFF_FFFF) begin e.resp = 2'd1; e.data = s[31:0]; end
            end
            4'd2: if (a >= b) begin e.resp = 2'd1; e.data = a - b; end
            4'd5: begin e.resp = 2'd1; e.data = a << amt; end
            4'd6: begin e.resp = 2'd1; e.data = a >> amt; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NI; i++) begin
                if (resp[i] != 2'd0) begin
                    if (q.size() == 0 || q[0].inst != i) begin
                        check($sformatf("unexpected_resp_inst%0d", i), 64'(resp[i]), 64'd0);
                    end else begin
                        mon_e = q.pop_front();
                        check($sformatf("resp_inst%0d", i), 64'(resp[i]), 64'(mon_e.resp));
                        check($sformatf("data_inst%0d", i), 64'(odat[i]), 64'(mon_e.data));
                        check($sformatf("beat_cycle_inst%0d", i), 64'(cyc), 64'(mon_e.cyc));
                        check($sformatf("busy_on_beat_inst%0d", i), 64'(bsy[i]), 64'd1);
                    end
                end else begin
                    check($sformatf("idle_data_inst%0d", i), 64'(odat[i]), 64'd0);
                end
            end
        end
    end

    task automatic issue(input int i, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
        int c0;
        int lat;
        c0  = cyc;
        lat = lat_of(i);
        q.push_back(model(i, c, a, b, c0 + 2 + lat));
        cmd[i] = c;
        dat[i] = a;
        tick();
        check("busy_after_cmd", 64'(bsy[i]), 64'd1);
        // command bus is don't-care during the operand2 cycle
        cmd[i] = 4'($urandom_range(0, 15));
        dat[i] = b;
        tick();
        cmd[i] = poke ? 4'd1 : 4'd0;
        dat[i] = $urandom;
        tick();
        cmd[i] = 4'd0;
        while (cyc < c0 + 3 + lat) tick();
        check("resp_after_beat", 64'(resp[i]), 64'd0);
        check("busy_after_beat", 64'(bsy[i]), 64'd0);
    endtask

    task automatic reset_hold(input int i);
        rst[i] = 1'b1;
        cmd[i] = 4'd1;
        dat[i] = $urandom;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst_resp", 64'(resp[i]), 64'd0);
            check("rst_data", 64'(odat[i]), 64'd0);
            check("rst_busy", 64'(bsy[i]), 64'd0);
        end
        rst[i] = 1'b0;
        cmd[i] = 4'd0;
        check("post_rst_busy", 64'(bsy[i]), 64'd0);
        tick();
        check("post_rst_resp", 64'(resp[i]), 64'd0);
        check("post_rst_busy2", 64'(bsy[i]), 64'd0);
    endtask

    task automatic reset_mid(input int i);
        cmd[i] = 4'd1;
        dat[i] = $urandom;
        tick();
        cmd[i] = 4'd0;
        dat[i] = $urandom;
        tick();
        rst[i] = 1'b1;
        tick();
        rst[i] = 1'b0;
        repeat (lat_of(i) + 20) tick();
        check("mid_rst_busy", 64'(bsy[i]), 64'd0);
        issue(i, 4'd1, 32'd2, 32'd2, 1'b0);
    endtask

    task automatic rand_ops(input int i, input int n);
        logic [3:0] c;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 5))
                0: c = 4'd1;
                1: c = 4'd2;
                2: c = 4'd5;
                3: c = 4'd6;
                4: c = 4'($urandom_range(3, 4));
                default: c = 4'($urandom_range(7, 15));
            endcase
            issue(i, c, $urandom, $urandom, bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] one;
        one = 32'd1;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            cmd[i] = 4'd0;
            dat[i] = 32'd0;
        end
        tick();
        mon_en = 1'b1;
        for (int i = 0; i < NI; i++) reset_hold(i);

        issue(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 1'b0);
        issue(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue(0, 4'd2, 32'h0000_0001, 32'h0000_000F, 1'b0);
        issue(0, 4'd2, 32'd5, 32'd5, 1'b0);
        issue(0, 4'd5, 32'h0000_0001, 32'd31, 1'b0);
        issue(0, 4'd6, 32'h8000_0000, 32'h23, 1'b0);
        issue(0, 4'd3, $urandom, $urandom, 1'b1);
        issue(0, 4'd1, 32'd5, 32'd7, 1'b1);
        for (int k = 0; k <= 30; k++) issue(0, 4'd1, one << k, 32'd0, 1'b0);
        reset_mid(0);
        rand_ops(0, 60);

        for (int i = 1; i < NI; i++) begin
            issue(i, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 1'b0);
            issue(i, 4'd5, 32'h0000_0001, 32'd31, 1'b0);
            issue(i, 4'd6, 32'h8000_0000, 32'h23, 1'b0);
            reset_mid(i);
            rand_ops(i, 20);
        end

        repeat (20) tick();
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
